// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the decode-to-execute pipeline stage:
//   - instruction field bit positions (opcode / rd / rs / rt)
//   - control bundle bit indices and default control width
//   - occupancy state encoding used when the skid buffer is built in
// ----------------------------------------------------------------------------
package pipe_pkg;

   localparam int CTRL_W_DEFAULT = 9;

   // Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS_HI  = 7;
   localparam int RS_LO  = 4;
   localparam int RT_HI  = 3;
   localparam int RT_LO  = 0;

   // Control bundle bit positions; bits 7 and 8 are spare
   localparam int CTRL_REGDST   = 0;
   localparam int CTRL_BRANCH   = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMTOREG = 3;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_ALUSRC   = 5;
   localparam int CTRL_REGWRITE = 6;

   // Stage occupancy: no entries, main only, main + skid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot
// One payload register: valid flag, control bundle and data word.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears everything)
//   i_clr         synchronous clear of valid and control (data left stale)
//   i_ld          load i_ctrl/i_data and set valid
//   i_ctrl/i_data payload to capture
//   o_valid/o_ctrl/o_data registered payload
// Priority: rst > i_clr > i_ld. Control is cleared together with valid so an
// empty slot can never present a live control bit.
// ----------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_BITS = 48,
   parameter int CTRL_BITS = CTRL_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_ld,
   input  logic [CTRL_BITS-1:0] i_ctrl,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_valid,
   output logic [CTRL_BITS-1:0] o_ctrl,
   output logic [DATA_BITS-1:0] o_data
);

   logic                 r_valid;
   logic [CTRL_BITS-1:0] r_ctrl;
   logic [DATA_BITS-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (i_ld) begin
         r_valid <= 1'b1;
         r_ctrl  <= i_ctrl;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register with valid/ready handshake, synchronous
// flush and an optional one-entry skid buffer.
// Build option: define ID_EX_SKID_EN for the two-entry (main + skid) version,
// whose in_ready comes from registered state only. Without it a single entry
// is used and in_ready follows out_ready combinationally.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop every held entry (and any offered payload)
//   in_valid/in_ready     upstream handshake
//   in_ops/in_imm/in_ctrl/in_instr  payload from decode
//   out_valid/out_ready   downstream handshake
//   out_ops/out_imm/out_ctrl        registered payload (ctrl zero when idle)
//   out_opcode/out_rd/out_rs/out_rt fields of the registered instruction
// ----------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int NUM_OPS = 2,
   parameter int CTRL_W  = CTRL_W_DEFAULT,
   parameter int INSTR_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic [DATA_W-1:0]         in_imm,
   input  logic [CTRL_W-1:0]         in_ctrl,
   input  logic [INSTR_W-1:0]        in_instr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [DATA_W-1:0]         out_imm,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [3:0]                out_opcode,
   output logic [3:0]                out_rd,
   output logic [3:0]                out_rs,
   output logic [3:0]                out_rt
);

   localparam int OPS_BITS = NUM_OPS * DATA_W;
   localparam int PAY_W    = OPS_BITS + DATA_W + INSTR_W;

   logic [PAY_W-1:0]   w_in_data;
   logic               w_in_ready;
   logic               w_in_fire;
   logic               w_main_ld;
   logic               w_main_clr;
   logic [PAY_W-1:0]   w_main_d;
   logic [CTRL_W-1:0]  w_main_ctrl_d;
   logic               w_main_valid;
   logic [CTRL_W-1:0]  w_main_ctrl;
   logic [PAY_W-1:0]   w_main_data;
   logic [INSTR_W-1:0] w_instr;

   assign w_in_data = {in_instr, in_imm, in_ops};
   assign w_in_fire = in_valid & w_in_ready;

`ifdef ID_EX_SKID_EN
   state_t            r_state;
   state_t            w_state_next;
   logic              w_skid_ld;
   logic              w_skid_clr;
   logic              w_skid_valid;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [PAY_W-1:0]  w_skid_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_main_ld    = 1'b0;
      w_main_clr   = 1'b0;
      w_skid_ld    = 1'b0;
      w_skid_clr   = 1'b0;
      if (flush) begin
         w_state_next = EMPTY;
         w_main_clr   = 1'b1;
         w_skid_clr   = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_state_next = BUSY;
                  w_main_ld    = 1'b1;
               end
            end
            BUSY: begin
               if (w_in_fire && out_ready) begin
                  w_main_ld = 1'b1;
               end else if (w_in_fire) begin
                  w_state_next = FULL;
                  w_skid_ld    = 1'b1;
               end else if (out_ready) begin
                  w_state_next = EMPTY;
                  w_main_clr   = 1'b1;
               end
            end
            FULL: begin
               if (out_ready) begin
                  w_state_next = BUSY;
                  w_main_ld    = 1'b1;
                  w_skid_clr   = 1'b1;
               end
            end
            default: begin
               w_state_next = EMPTY;
            end
         endcase
      end
   end

   // Registered-only ready: no path from out_ready
   assign w_in_ready = (r_state != FULL) & ~rst;

   // Skid holds a payload only in FULL, which is exactly when main must
   // refill from it instead of from the input.
   assign w_main_d      = w_skid_valid ? w_skid_data : w_in_data;
   assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : in_ctrl;

   pipe_slot #(
      .DATA_BITS (PAY_W),
      .CTRL_BITS (CTRL_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_skid_clr),
      .i_ld    (w_skid_ld),
      .i_ctrl  (in_ctrl),
      .i_data  (w_in_data),
      .o_valid (w_skid_valid),
      .o_ctrl  (w_skid_ctrl),
      .o_data  (w_skid_data)
   );
`else
   // Single entry: accept when empty or when the held payload leaves now
   assign w_in_ready    = (out_ready | ~w_main_valid) & ~rst;
   assign w_main_ld     = w_in_fire;
   assign w_main_clr    = flush | (w_main_valid & out_ready & ~w_in_fire);
   assign w_main_d      = w_in_data;
   assign w_main_ctrl_d = in_ctrl;
`endif

   pipe_slot #(
      .DATA_BITS (PAY_W),
      .CTRL_BITS (CTRL_W)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_main_clr),
      .i_ld    (w_main_ld),
      .i_ctrl  (w_main_ctrl_d),
      .i_data  (w_main_d),
      .o_valid (w_main_valid),
      .o_ctrl  (w_main_ctrl),
      .o_data  (w_main_data)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = w_main_valid;
   assign out_ctrl  = w_main_ctrl;
   assign out_ops   = w_main_data[OPS_BITS-1:0];
   assign out_imm   = w_main_data[OPS_BITS +: DATA_W];
   assign w_instr   = w_main_data[OPS_BITS+DATA_W +: INSTR_W];

   assign out_opcode = w_instr[OPC_HI:OPC_LO];
   assign out_rd     = w_instr[RD_HI:RD_LO];
   assign out_rs     = w_instr[RS_HI:RS_LO];
   assign out_rt     = w_instr[RT_HI:RT_LO];

endmodule
